// File: rtl/fc3_acc_dff.sv
// fc3 accumulator: counts ones of the per-product bitstreams over a CYCLE-clock
// window per fold pass and hands the lane sums downstream with valid/ready.
//
// state  | meaning
// S_IDLE | waiting for start; last result and fold index held
// S_ACC  | sampling iFmbs/iEn, acc=1, down-counting the window
// S_OUT  | result presented with oValid, waiting for iReady
module fc3_acc_dff #(
   parameter int IDIM  = 1,
   parameter int FOLD  = 1,
   parameter int ODIM  = 1,
   parameter int CYCLE = 256,
   parameter int SW    = $clog2(IDIM*CYCLE+1)
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                start,
   input  logic [ODIM/FOLD*IDIM-1:0]           iFmbs,
   input  logic [ODIM/FOLD*IDIM-1:0]           iEn,
   output logic                                acc,
   output logic [ODIM/FOLD-1:0][SW-1:0]        oSum,
   output logic [ODIM/FOLD-1:0][SW-1:0]        oEnSum,
   output logic [$clog2(FOLD):0]               oFold,
   output logic                                oValid,
   input  logic                                iReady,
   output logic                                done
);

   localparam int LANES = ODIM/FOLD;
   localparam int PW    = $clog2(IDIM+1);
   localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
   localparam int FW    = $clog2(FOLD) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cyc_left_q, cyc_left_d;
   logic [FW-1:0]              fold_q, fold_d;
   logic [LANES-1:0][SW-1:0]   sum_q, sum_d;
   logic [LANES-1:0][SW-1:0]   en_q, en_d;
   logic [LANES-1:0][SW-1:0]   out_sum_q, out_sum_d;
   logic [LANES-1:0][SW-1:0]   out_en_q, out_en_d;
   logic                       done_q, done_d;
   logic                       start_ok;
   logic                       window_end;
   logic                       xfer;
   logic                       last_fold;

   function automatic logic [PW-1:0] popcnt(input logic [IDIM-1:0] v);
      logic [PW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < IDIM; i++) begin
         cnt = cnt + PW'(v[i]);
      end
      return cnt;
   endfunction

   // a start coinciding with the done pulse belongs to the finished run
   assign start_ok   = start && !done_q;
   assign window_end = (cyc_left_q == '0);
   assign xfer       = (state_q == S_OUT) && iReady;
   assign last_fold  = (fold_q == FW'(FOLD-1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_ok)   state_d = S_ACC;
         S_ACC:  if (window_end) state_d = S_OUT;
         S_OUT:  if (xfer)       state_d = last_fold ? S_IDLE : S_ACC;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc    = 1'b0;
      oValid = 1'b0;
      case (state_q)
         S_ACC:   acc    = 1'b1;
         S_OUT:   oValid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cyc_left_d = cyc_left_q;
      fold_d     = fold_q;
      sum_d      = sum_q;
      en_d       = en_q;
      out_sum_d  = out_sum_q;
      out_en_d   = out_en_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               cyc_left_d = CW'(CYCLE-1);
               fold_d     = '0;
               sum_d      = '0;
               en_d       = '0;
            end
         end
         S_ACC: begin
            for (int l = 0; l < LANES; l++) begin
               sum_d[l] = sum_q[l] + SW'(popcnt(iFmbs[l*IDIM +: IDIM] & iEn[l*IDIM +: IDIM]));
               en_d[l]  = en_q[l]  + SW'(popcnt(iEn[l*IDIM +: IDIM]));
            end
            if (window_end) begin
               // result registers load with the final sample so they are steady for all of OUT
               out_sum_d = sum_d;
               out_en_d  = en_d;
            end else begin
               cyc_left_d = cyc_left_q - CW'(1);
            end
         end
         S_OUT: begin
            if (xfer) begin
               if (last_fold) begin
                  done_d = 1'b1;
               end else begin
                  fold_d     = fold_q + FW'(1);
                  cyc_left_d = CW'(CYCLE-1);
                  sum_d      = '0;
                  en_d       = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cyc_left_q <= '0;
         fold_q     <= '0;
         sum_q      <= '0;
         en_q       <= '0;
         out_sum_q  <= '0;
         out_en_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         cyc_left_q <= cyc_left_d;
         fold_q     <= fold_d;
         sum_q      <= sum_d;
         en_q       <= en_d;
         out_sum_q  <= out_sum_d;
         out_en_q   <= out_en_d;
         done_q     <= done_d;
      end
   end

   assign oSum   = out_sum_q;
   assign oEnSum = out_en_q;
   assign oFold  = fold_q;
   assign done   = done_q;

endmodule

// File: tb/tb_fc3_acc_dff.sv
// Directed bench for fc3_acc_dff: three parameterisations share one clock/reset.
module tb_fc3_acc_dff;

   logic clk;
   logic rstn;

   // A: IDIM=4 FOLD=1 ODIM=1 CYCLE=8 (SW=6)
   logic             a_start, a_acc, a_valid, a_ready, a_done;
   logic [3:0]       a_fm, a_en;
   logic [0:0][5:0]  a_sum, a_ensum;
   logic [0:0]       a_fold;

   // B: IDIM=2 FOLD=2 ODIM=4 CYCLE=4 (2 lanes, SW=4)
   logic             b_start, b_acc, b_valid, b_ready, b_done;
   logic [3:0]       b_fm, b_en;
   logic [1:0][3:0]  b_sum, b_ensum;
   logic [1:0]       b_fold;

   // C: IDIM=3 FOLD=1 ODIM=1 CYCLE=1 (SW=2)
   logic             c_start, c_acc, c_valid, c_ready, c_done;
   logic [2:0]       c_fm, c_en;
   logic [0:0][1:0]  c_sum, c_ensum;
   logic [0:0]       c_fold;

   int n_cmp = 0;
   int n_err = 0;

   fc3_acc_dff #(.IDIM(4), .FOLD(1), .ODIM(1), .CYCLE(8)) u_a (
      .clk(clk), .rstn(rstn), .start(a_start), .iFmbs(a_fm), .iEn(a_en),
      .acc(a_acc), .oSum(a_sum), .oEnSum(a_ensum), .oFold(a_fold),
      .oValid(a_valid), .iReady(a_ready), .done(a_done));

   fc3_acc_dff #(.IDIM(2), .FOLD(2), .ODIM(4), .CYCLE(4)) u_b (
      .clk(clk), .rstn(rstn), .start(b_start), .iFmbs(b_fm), .iEn(b_en),
      .acc(b_acc), .oSum(b_sum), .oEnSum(b_ensum), .oFold(b_fold),
      .oValid(b_valid), .iReady(b_ready), .done(b_done));

   fc3_acc_dff #(.IDIM(3), .FOLD(1), .ODIM(1), .CYCLE(1)) u_c (
      .clk(clk), .rstn(rstn), .start(c_start), .iFmbs(c_fm), .iEn(c_en),
      .acc(c_acc), .oSum(c_sum), .oEnSum(c_ensum), .oFold(c_fold),
      .oValid(c_valid), .iReady(c_ready), .done(c_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // start a window on A; returns acc-high cycles and ticks until oValid (start edge counts as 1)
   task automatic a_run(input logic [3:0] fm, input logic [3:0] en, input int spur_at,
                        output int acc_n, output int lat);
      a_fm    = fm;
      a_en    = en;
      a_ready = 1'b0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      acc_n   = 0;
      lat     = 1;
      while (!a_valid && lat < 40) begin
         if (a_acc) acc_n++;
         a_start = (lat == spur_at);
         tick();
         lat++;
      end
      a_start = 1'b0;
   endtask

   task automatic a_accept(input string tag);
      a_ready = 1'b1;
      tick();
      chk({tag, "_done"}, 32'(a_done), 32'd1);
      chk({tag, "_valid_drop"}, 32'(a_valid), 32'd0);
      a_ready = 1'b0;
      tick();
      chk({tag, "_done_once"}, 32'(a_done), 32'd0);
   endtask

   initial begin
      int acc_n;
      int lat;
      int nb;
      rstn = 1'b0;
      a_start = 0; a_ready = 0; a_fm = '0; a_en = '0;
      b_start = 0; b_ready = 0; b_fm = '0; b_en = '0;
      c_start = 0; c_ready = 0; c_fm = '0; c_en = '0;
      tick();
      tick();
      chk("rst_a_acc",   32'(a_acc),   32'd0);
      chk("rst_a_valid", 32'(a_valid), 32'd0);
      chk("rst_a_sum",   32'(a_sum[0]), 32'd0);
      chk("rst_a_done",  32'(a_done),  32'd0);
      chk("rst_b_fold",  32'(b_fold),  32'd0);
      chk("rst_c_valid", 32'(c_valid), 32'd0);
      rstn = 1'b1;
      tick();

      // all-ones stream
      a_run(4'hF, 4'hF, -1, acc_n, lat);
      chk("ones_lat",   32'(lat),   32'd9);
      chk("ones_accn",  32'(acc_n), 32'd8);
      chk("ones_sum",   32'(a_sum[0]),   32'd32);
      chk("ones_ensum", 32'(a_ensum[0]), 32'd32);
      chk("ones_fold",  32'(a_fold), 32'd0);
      chk("ones_acc0",  32'(a_acc),  32'd0);
      a_accept("ones");
      chk("ones_retain", 32'(a_sum[0]), 32'd32);

      // reset three cycles into the window
      a_fm = 4'hF; a_en = 4'hF;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick(); tick(); tick();
      rstn = 1'b0;
      #1;
      chk("rstacc_acc",   32'(a_acc),   32'd0);
      chk("rstacc_valid", 32'(a_valid), 32'd0);
      chk("rstacc_sum",   32'(a_sum[0]), 32'd0);
      rstn = 1'b1;
      tick();
      chk("rstacc_idle", 32'(a_acc), 32'd0);
      a_run(4'hF, 4'hF, -1, acc_n, lat);
      chk("rstacc_accn", 32'(acc_n), 32'd8);
      chk("rstacc_lat",  32'(lat),   32'd9);
      chk("rstacc_sum2", 32'(a_sum[0]), 32'd32);
      a_accept("rstacc");

      // enable masking
      a_run(4'hF, 4'b0011, -1, acc_n, lat);
      chk("mask1_sum",   32'(a_sum[0]),   32'd16);
      chk("mask1_ensum", 32'(a_ensum[0]), 32'd16);
      a_accept("mask1");
      a_run(4'b0101, 4'b0011, -1, acc_n, lat);
      chk("mask2_sum",   32'(a_sum[0]),   32'd8);
      chk("mask2_ensum", 32'(a_ensum[0]), 32'd16);
      a_accept("mask2");

      // spurious start in ACC and in OUT
      a_run(4'hF, 4'hF, 3, acc_n, lat);
      chk("spur_lat",  32'(lat),   32'd9);
      chk("spur_accn", 32'(acc_n), 32'd8);
      chk("spur_sum",  32'(a_sum[0]), 32'd32);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("spur_out_valid", 32'(a_valid), 32'd1);
      chk("spur_out_acc",   32'(a_acc),   32'd0);
      chk("spur_out_sum",   32'(a_sum[0]), 32'd32);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      chk("spur_done", 32'(a_done), 32'd1);
      // start alongside done must not launch a new run
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("spur_done_once", 32'(a_done), 32'd0);
      chk("start_on_done",  32'(a_acc),  32'd0);
      tick();
      chk("start_on_done2", 32'(a_acc),  32'd0);

      // fold walk with backpressure; lane 1 has no enables
      b_fm = 4'b1111; b_en = 4'b0011; b_ready = 1'b0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      lat = 1;
      while (!b_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("fold0_lat",    32'(lat), 32'd5);
      chk("fold0_fold",   32'(b_fold), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("fold0_hold_valid", 32'(b_valid), 32'd1);
         chk("fold0_hold_acc",   32'(b_acc),   32'd0);
         chk("fold0_sum0",   32'(b_sum[0]),   32'd8);
         chk("fold0_sum1",   32'(b_sum[1]),   32'd0);
         chk("fold0_ensum0", 32'(b_ensum[0]), 32'd8);
         chk("fold0_ensum1", 32'(b_ensum[1]), 32'd0);
         tick();
      end
      b_ready = 1'b1;
      tick();
      chk("fold0_no_done", 32'(b_done), 32'd0);
      nb = 0;
      while (b_acc && nb < 40) begin
         nb++;
         tick();
      end
      chk("fold1_accn",  32'(nb), 32'd4);
      chk("fold1_valid", 32'(b_valid), 32'd1);
      chk("fold1_fold",  32'(b_fold),  32'd1);
      chk("fold1_sum0",  32'(b_sum[0]), 32'd8);
      chk("fold1_sum1",  32'(b_sum[1]), 32'd0);
      tick();
      chk("fold_done",      32'(b_done),  32'd1);
      chk("fold_valid_off", 32'(b_valid), 32'd0);
      b_ready = 1'b0;
      tick();
      chk("fold_done_once", 32'(b_done), 32'd0);
      chk("fold_idle_acc",  32'(b_acc),  32'd0);

      // CYCLE=1 boundary
      c_fm = 3'b111; c_en = 3'b101; c_ready = 1'b0;
      c_start = 1'b1;
      tick();
      c_start = 1'b0;
      chk("c1_acc_on",  32'(c_acc),   32'd1);
      tick();
      chk("c1_acc_off", 32'(c_acc),   32'd0);
      chk("c1_valid",   32'(c_valid), 32'd1);
      chk("c1_sum",     32'(c_sum[0]),   32'd2);
      chk("c1_ensum",   32'(c_ensum[0]), 32'd2);
      c_ready = 1'b1;
      tick();
      chk("c1_done", 32'(c_done), 32'd1);
      c_ready = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
